// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: XLEN-step shift-add multiply or restoring divide, then sign fixup.
// Optional MULDIV_EARLY_OUT_EN: zero/div-by-zero/overflow operands skip the iteration phase.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_stall,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_s1,
    input  logic [XLEN-1:0] in_s2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_stall,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_val,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     raw_s1, raw_s2;
    logic [XLEN-1:0]     dvs;
    logic [2*XLEN-1:0]   acc;
    logic                s1_neg, s2_neg;

    logic                accept, early;
    logic                s1_sgn, s2_sgn, in_s1_neg, in_s2_neg;
    logic [XLEN-1:0]     mag1, mag2;
    logic [XLEN:0]       mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]   acc_mul, acc_div, prod;
    logic [XLEN-1:0]     quo, rem, res;

    assign in_stall = (state != IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && (state == IDLE) && !flush;

    assign s1_sgn    = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
    assign s2_sgn    = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    assign in_s1_neg = s1_sgn && in_s1[XLEN-1];
    assign in_s2_neg = s2_sgn && in_s2[XLEN-1];
    assign mag1      = in_s1_neg ? -in_s1 : in_s1;
    assign mag2      = in_s2_neg ? -in_s2 : in_s2;

`ifdef MULDIV_EARLY_OUT_EN
    // Operands whose result is fully determined by the FIXUP overrides need no iterations.
    assign early = (in_s1 == '0) || (in_op[2] ? (in_s2 == '0) : (in_s2 == '0))
                 || (in_op[2] && !in_op[0] && in_s1 == SMIN && in_s2 == '1);
`else
    assign early = 1'b0;
`endif

    // Upper half is the running product / partial remainder, lower half the multiplier / dividend.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    assign acc_mul  = {mul_sum, acc[XLEN-1:1]};
    assign div_sh   = acc[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, dvs};
    assign acc_div  = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    always_comb begin
        prod = (s1_neg ^ s2_neg) ? -acc : acc;
        quo  = (s1_neg ^ s2_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = s1_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:                res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          res = quo;
            default:             res = rem;
        endcase
        if (op_q[2] && raw_s2 == '0)
            res = op_q[1] ? raw_s1 : '1;
        else if (op_q[2] && !op_q[0] && raw_s1 == SMIN && raw_s2 == '1)
            res = op_q[1] ? '0 : SMIN;
        else if (raw_s1 == '0 || (!op_q[2] && raw_s2 == '0))
            res = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = early ? FIXUP : CALC;
            CALC:    if (cnt == CNT_W'(XLEN-1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (!out_stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_val   <= '0;
        end else if (flush) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= in_op;
                    rd_q   <= in_rd;
                    raw_s1 <= in_s1;
                    raw_s2 <= in_s2;
                    s1_neg <= in_s1_neg;
                    s2_neg <= in_s2_neg;
                    dvs    <= mag2;
                    acc    <= {{XLEN{1'b0}}, mag1};
                    cnt    <= '0;
                end
                CALC: begin
                    acc <= op_q[2] ? acc_div : acc_mul;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    out_val   <= res;
                    out_rd    <= rd_q;
                    out_valid <= 1'b1;
                end
                DONE: if (!out_stall) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer with a result scoreboard.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_stall;
    logic [2:0]  in_op = '0;
    logic [31:0] in_s1 = '0;
    logic [31:0] in_s2 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_stall = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_val;
    logic        busy;

    muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_stall(in_stall), .in_op(in_op),
        .in_s1(in_s1), .in_s2(in_s2), .in_rd(in_rd),
        .out_valid(out_valid), .out_stall(out_stall),
        .out_rd(out_rd), .out_val(out_val), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] expv;
    } vec_t;

    exp_t sb[$];
    vec_t vecs [0:14];
    int   tests = 0;
    int   fails = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb2, ua, ub, p;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        r   = '0;
        case (op)
            3'd0: begin p = sa * sb2; r = p[31:0];  end
            3'd1: begin p = sa * sb2; r = p[63:32]; end
            3'd2: begin p = sa * ub;  r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                  else begin p = sa / sb2; r = p[31:0]; end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                  else begin p = sa % sb2; r = p[31:0]; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (a == 0) || (b == 0)
               || ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return (EARLY && special) ? 1 : 33;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expv, input bit track);
        check("idle_before_issue", in_stall, 1'b0);
        in_op = op; in_s1 = a; in_s2 = b; in_rd = rd; in_valid = 1'b1;
        if (track) sb.push_back('{rd: rd, val: expv, lat: exp_lat(op, a, b)});
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input bit hold, input bit consume);
        exp_t e;
        int   k = 0;
        bit   stall_ok = 1'b1;
        if (hold) in_valid = 1'b1;
        while (!out_valid && k < 200) begin
            if (hold) begin
                if (!in_stall) stall_ok = 1'b0;
                in_s1 = $urandom;
                in_s2 = $urandom;
            end
            step();
            k++;
        end
        if (hold) begin
            in_valid = 1'b0;
            check({tag, "_stall_held"}, stall_ok, 1'b1);
        end
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, k, e.lat);
            check({tag, "_val"}, out_val, e.val);
            check({tag, "_rd"}, out_rd, e.rd);
        end
        if (consume && !out_stall) begin
            step();
            check({tag, "_drop_valid"}, out_valid, 1'b0);
            check({tag, "_idle"}, busy, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          seen;

        vecs = '{
            '{3'd1, 32'hFFFFFFFF, 32'd2,        5'd1,  32'hFFFFFFFF},
            '{3'd3, 32'hFFFFFFFF, 32'd2,        5'd2,  32'h00000001},
            '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFD},
            '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFF},
            '{3'd5, 32'd100,      32'd7,        5'd6,  32'd14},
            '{3'd7, 32'd100,      32'd7,        5'd7,  32'd2},
            '{3'd4, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF},
            '{3'd6, 32'd5,        32'd0,        5'd10, 32'd5},
            '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000},
            '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000},
            '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000},
            '{3'd0, 32'd0,        32'h12345,    5'd15, 32'h00000000},
            '{3'd5, 32'd0,        32'd0,        5'd16, 32'hFFFFFFFF},
            '{3'd7, 32'd0,        32'd0,        5'd17, 32'h00000000},
            '{3'd1, 32'h80000000, 32'h80000000, 5'd18, 32'h40000000}
        };

        // Reset held with an op offered: nothing happens.
        in_valid = 1'b1; in_op = 3'd0; in_s1 = 32'd7; in_s2 = 32'd6; in_rd = 5'd5;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_out_valid", out_valid, 1'b0);
            check("reset_busy", busy, 1'b0);
            check("reset_in_stall", in_stall, 1'b0);
        end
        check("reset_out_rd", out_rd, 5'd0);
        check("reset_out_val", out_val, 32'd0);

        // Releasing reset: the held op is taken on the next edge.
        rst = 1'b1;
        sb.push_back('{rd: 5'd5, val: 32'd42, lat: exp_lat(3'd0, 32'd7, 32'd6)});
        step();
        in_valid = 1'b0;
        check("accept_after_reset_busy", busy, 1'b1);
        wait_result("mul_7x6", 1'b0, 1'b1);

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].expv, 1'b1);
            wait_result($sformatf("vec%0d_op%0d", i, vecs[i].op), 1'b0, 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            issue(rop, ra, rb, 5'(i + 20), model(rop, ra, rb), 1'b1);
            wait_result($sformatf("rand%0d_op%0d", i, rop), 1'b0, 1'b1);
        end

        // Backpressure: result held 10 cycles while a second op waits.
        out_stall = 1'b1;
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1'b1);
        wait_result("bp_first", 1'b0, 1'b1);
        in_op = 3'd0; in_s1 = 32'h12345678; in_s2 = 32'h10; in_rd = 5'd9; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_val_held", out_val, 32'h80000000);
            check("bp_rd_held", out_rd, 5'd19);
            check("bp_in_stall", in_stall, 1'b1);
            step();
        end
        out_stall = 1'b0;
        step();
        check("bp_exit_valid", out_valid, 1'b0);
        check("bp_exit_idle", busy, 1'b0);
        sb.push_back('{rd: 5'd9, val: 32'h23456780, lat: 33});
        step();
        in_valid = 1'b0;
        check("bp_second_busy", busy, 1'b1);
        wait_result("bp_second", 1'b0, 1'b1);

        // Flush at E+10 during iteration: op vanishes.
        issue(3'd5, 32'd1000, 32'd3, 5'd20, 32'd333, 1'b0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_calc_busy", busy, 1'b0);
        check("flush_calc_valid", out_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("flush_calc_no_result", seen, 1'b0);

        // Flush in DONE with out_stall low, op offered in the same cycle.
        issue(3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 1'b1);
        wait_result("flush_done_pre", 1'b0, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 3'd0; in_s1 = 32'd9; in_s2 = 32'd9; in_rd = 5'd3;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_done_valid", out_valid, 1'b0);
        check("flush_done_busy", busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("flush_done_no_repeat", seen, 1'b0);

        // Flush while idle with an op offered: not accepted.
        in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_no_accept", busy, 1'b0);

        // Operands wiggle after acceptance; result must use the sampled ones.
        issue(3'd4, 32'd1000, 32'hFFFFFFF6, 5'd22, 32'hFFFFFF9C, 1'b1);
        wait_result("issue_hold", 1'b1, 1'b1);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
